// File: rtl/perf_pkg.sv
// Shared types and constants for the performance counter bank:
// register field map, CTRL bit layout and default sizing.
package perf_pkg;

  localparam int EVENT_NUM_DEF = 32;
  localparam int INC_WIDTH_DEF = 3;
  localparam int CNT_NUM_DEF   = 8;
  localparam int CNT_WIDTH_DEF = 48;
  localparam int DATA_W        = 32;

  typedef enum logic [1:0] {
    FLD_SEL    = 2'd0,
    FLD_CNT_LO = 2'd1,
    FLD_CNT_HI = 2'd2,
    FLD_CTRL   = 2'd3
  } perf_field_e;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_OVF_BIT    = 1;
  localparam int CTRL_OVF_EN_BIT = 2;

  typedef struct packed {
    logic ovf_en;
    logic ovf;
    logic enable;
  } perf_ctrl_t;

  function automatic logic [DATA_W-1:0] ctrl_to_word(input perf_ctrl_t c);
    logic [DATA_W-1:0] w;
    w = '0;
    w[CTRL_EN_BIT]     = c.enable;
    w[CTRL_OVF_BIT]    = c.ovf;
    w[CTRL_OVF_EN_BIT] = c.ovf_en;
    return w;
  endfunction

endpackage

// File: rtl/perf_counter_slice.sv
// One counter: event selector mux, wide adder with carry-out overflow
// detection, and the per-counter SEL / CTRL registers.
module perf_counter_slice
  import perf_pkg::*;
#(
  parameter int EVENT_NUM = EVENT_NUM_DEF,
  parameter int INC_WIDTH = INC_WIDTH_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF,
  parameter int EVT_BITS  = $clog2(EVENT_NUM)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [EVENT_NUM*INC_WIDTH-1:0] ev_i,
  input  logic                           freeze_i,
  input  logic                           wr_en_i,
  input  perf_field_e                    wr_field_i,
  input  logic [DATA_W-1:0]              wr_data_i,
  output logic [CNT_WIDTH-1:0]           cnt_o,
  output logic [EVT_BITS-1:0]            sel_o,
  output perf_ctrl_t                     ctrl_o,
  output logic                           irq_o
);

  localparam int HI_W = CNT_WIDTH - 32;

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [EVT_BITS-1:0]  sel_q, sel_d;
  perf_ctrl_t           ctrl_q, ctrl_d;

  logic [INC_WIDTH-1:0] inc;
  logic [CNT_WIDTH:0]   sum;
  logic                 cnt_wr;
  logic                 add_en;
  logic                 ovf_set;

  // Selector values that name no event contribute nothing.
  always_comb begin
    inc = '0;
    for (int e = 0; e < EVENT_NUM; e++) begin
      if (sel_q == EVT_BITS'(e)) inc = ev_i[e*INC_WIDTH +: INC_WIDTH];
    end
  end

  // A software write to the counter value replaces this cycle's increment.
  assign cnt_wr  = wr_en_i && (wr_field_i == FLD_CNT_LO || wr_field_i == FLD_CNT_HI);
  assign add_en  = ctrl_q.enable && !freeze_i && !cnt_wr;
  assign sum     = {1'b0, cnt_q} + {{(CNT_WIDTH + 1 - INC_WIDTH){1'b0}}, inc};
  assign ovf_set = add_en && sum[CNT_WIDTH];

  always_comb begin
    cnt_d  = cnt_q;
    sel_d  = sel_q;
    ctrl_d = ctrl_q;
    if (add_en) cnt_d = sum[CNT_WIDTH-1:0];
    if (wr_en_i) begin
      case (wr_field_i)
        FLD_SEL:    sel_d = wr_data_i[EVT_BITS-1:0];
        FLD_CNT_LO: cnt_d[31:0] = wr_data_i;
        FLD_CNT_HI: cnt_d[CNT_WIDTH-1:32] = wr_data_i[HI_W-1:0];
        FLD_CTRL: begin
          ctrl_d.enable = wr_data_i[CTRL_EN_BIT];
          ctrl_d.ovf_en = wr_data_i[CTRL_OVF_EN_BIT];
          if (wr_data_i[CTRL_OVF_BIT]) ctrl_d.ovf = 1'b0;
        end
        default: ;
      endcase
    end
    // Set beats a same-cycle W1C clear.
    if (ovf_set) ctrl_d.ovf = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      sel_q  <= '0;
      ctrl_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      sel_q  <= sel_d;
      ctrl_q <= ctrl_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign sel_o  = sel_q;
  assign ctrl_o = ctrl_q;
  assign irq_o  = ctrl_q.enable && ctrl_q.ovf && ctrl_q.ovf_en;

endmodule

// File: rtl/perf_counter_bank.sv
// Performance counter bank: registers per-cycle event increments, routes them
// into CNT_NUM selectable counters and serves the CSR register port.
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int EVENT_NUM = EVENT_NUM_DEF,
  parameter int INC_WIDTH = INC_WIDTH_DEF,
  parameter int CNT_NUM   = CNT_NUM_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF,
  parameter int EVT_BITS  = $clog2(EVENT_NUM),
  parameter int ADDR_W    = $clog2(CNT_NUM) + 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [EVENT_NUM*INC_WIDTH-1:0] event_inc,
  input  logic                           freeze,
  input  logic                           req_valid,
  input  logic                           req_we,
  input  logic [ADDR_W-1:0]              req_addr,
  input  logic [DATA_W-1:0]              req_wdata,
  output logic                           resp_valid,
  output logic [DATA_W-1:0]              resp_rdata,
  output logic                           irq
);

  localparam int IDX_W = ADDR_W - 2;
  localparam int HI_W  = CNT_WIDTH - 32;

  // Register port: no backpressure, every req_valid cycle is accepted and
  // answered by a one-cycle resp_valid pulse on the following cycle; read
  // data reflects register state before that cycle's update, writes return 0.

  logic [EVENT_NUM*INC_WIDTH-1:0] ev_q;
  logic [HI_W-1:0]                shadow_q, shadow_d;
  logic                           resp_valid_q;
  logic [DATA_W-1:0]              resp_rdata_q, resp_rdata_d;
  logic                           irq_q;

  logic [IDX_W-1:0]     req_idx;
  perf_field_e          req_fld;
  logic                 rd_req;
  logic [CNT_NUM-1:0]   wr_hit;
  logic [CNT_NUM-1:0]   irq_w;
  logic [CNT_WIDTH-1:0] cnt_w  [CNT_NUM];
  logic [EVT_BITS-1:0]  sel_w  [CNT_NUM];
  perf_ctrl_t           ctrl_w [CNT_NUM];

  assign req_idx = req_addr[ADDR_W-1:2];
  assign req_fld = perf_field_e'(req_addr[1:0]);
  assign rd_req  = req_valid && !req_we;

  for (genvar g = 0; g < CNT_NUM; g++) begin : g_cnt
    assign wr_hit[g] = req_valid && req_we && (req_idx == IDX_W'(g));

    perf_counter_slice #(
      .EVENT_NUM (EVENT_NUM),
      .INC_WIDTH (INC_WIDTH),
      .CNT_WIDTH (CNT_WIDTH),
      .EVT_BITS  (EVT_BITS)
    ) u_slice (
      .clk        (clk),
      .rst        (rst),
      .ev_i       (ev_q),
      .freeze_i   (freeze),
      .wr_en_i    (wr_hit[g]),
      .wr_field_i (req_fld),
      .wr_data_i  (req_wdata),
      .cnt_o      (cnt_w[g]),
      .sel_o      (sel_w[g]),
      .ctrl_o     (ctrl_w[g]),
      .irq_o      (irq_w[g])
    );
  end

  // Indices past CNT_NUM match no slice, so they read 0 and leave the shadow alone.
  always_comb begin
    resp_rdata_d = '0;
    shadow_d     = shadow_q;
    if (rd_req) begin
      for (int i = 0; i < CNT_NUM; i++) begin
        if (req_idx == IDX_W'(i)) begin
          case (req_fld)
            FLD_SEL:    resp_rdata_d = DATA_W'(sel_w[i]);
            FLD_CNT_LO: begin
              resp_rdata_d = cnt_w[i][31:0];
              shadow_d     = cnt_w[i][CNT_WIDTH-1:32];
            end
            FLD_CNT_HI: resp_rdata_d = DATA_W'(shadow_q);
            FLD_CTRL:   resp_rdata_d = ctrl_to_word(ctrl_w[i]);
            default:    resp_rdata_d = '0;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ev_q         <= '0;
      shadow_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      irq_q        <= 1'b0;
    end else begin
      ev_q         <= event_inc;
      shadow_q     <= shadow_d;
      resp_valid_q <= req_valid;
      resp_rdata_q <= resp_rdata_d;
      irq_q        <= |irq_w;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench for perf_counter_bank with a rule-level reference model
// checked every cycle, plus hand-computed register readbacks.
module tb_perf_counter_bank;

  localparam int EVN  = 32;
  localparam int INCW = 3;
  localparam int CNTN = 8;
  localparam logic [63:0] CNT_MOD = 64'h0001_0000_0000_0000;
  localparam logic [63:0] TWO32   = 64'h0000_0001_0000_0000;

  logic              clk = 1'b0;
  logic              rst;
  logic [EVN*INCW-1:0] event_inc;
  logic              freeze;
  logic              req_valid;
  logic              req_we;
  logic [4:0]        req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid, resp_valid6;
  logic [31:0]       resp_rdata, resp_rdata6;
  logic              irq, irq6;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  perf_counter_bank u_dut (
    .clk (clk), .rst (rst), .event_inc (event_inc), .freeze (freeze),
    .req_valid (req_valid), .req_we (req_we), .req_addr (req_addr),
    .req_wdata (req_wdata), .resp_valid (resp_valid), .resp_rdata (resp_rdata),
    .irq (irq)
  );

  // Second instance with fewer counters so out-of-range indices are addressable.
  perf_counter_bank #(.CNT_NUM(6)) u_dut6 (
    .clk (clk), .rst (rst), .event_inc (event_inc), .freeze (freeze),
    .req_valid (req_valid), .req_we (req_we), .req_addr (req_addr),
    .req_wdata (req_wdata), .resp_valid (resp_valid6), .resp_rdata (resp_rdata6),
    .irq (irq6)
  );

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [63:0] m_cnt [CNTN];
  int          m_sel [CNTN];
  bit          m_en [CNTN], m_ovf [CNTN], m_oen [CNTN];
  int          m_ev [EVN];
  logic [63:0] m_shadow;
  bit          m_rv, m_irq;
  logic [31:0] m_rd;

  int          mi_idx, mi_fld, mi_inc;
  logic [63:0] mi_nxt;
  bit          mi_carry, mi_irq;
  logic [31:0] mi_rd;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CNTN; i++) begin
        m_cnt[i] = 0; m_sel[i] = 0; m_en[i] = 0; m_ovf[i] = 0; m_oen[i] = 0;
      end
      for (int e = 0; e < EVN; e++) m_ev[e] = 0;
      m_shadow = 0; m_rv = 0; m_rd = 0; m_irq = 0;
    end else begin
      mi_irq = 0;
      for (int i = 0; i < CNTN; i++) if (m_en[i] && m_ovf[i] && m_oen[i]) mi_irq = 1;
      mi_idx = int'(req_addr[4:2]);
      mi_fld = int'(req_addr[1:0]);
      mi_rd  = 0;
      if (req_valid && !req_we) begin
        case (mi_fld)
          0: mi_rd = 32'(m_sel[mi_idx]);
          1: begin mi_rd = m_cnt[mi_idx][31:0]; m_shadow = m_cnt[mi_idx] / TWO32; end
          2: mi_rd = m_shadow[31:0];
          default: mi_rd = 32'(int'(m_en[mi_idx]) + 2 * int'(m_ovf[mi_idx]) + 4 * int'(m_oen[mi_idx]));
        endcase
      end
      for (int i = 0; i < CNTN; i++) begin
        mi_inc   = (m_en[i] && !freeze) ? m_ev[m_sel[i]] : 0;
        mi_nxt   = m_cnt[i] + 64'(mi_inc);
        mi_carry = 0;
        if (mi_nxt >= CNT_MOD) begin mi_nxt = mi_nxt - CNT_MOD; mi_carry = 1; end
        if (req_valid && req_we && mi_idx == i) begin
          case (mi_fld)
            0: m_sel[i] = int'(req_wdata % 32);
            1: begin mi_nxt = (m_cnt[i] / TWO32) * TWO32 + 64'(req_wdata); mi_carry = 0; end
            2: begin mi_nxt = 64'(req_wdata % 65536) * TWO32 + (m_cnt[i] % TWO32); mi_carry = 0; end
            default: begin
              m_en[i]  = req_wdata[0];
              m_oen[i] = req_wdata[2];
              if (req_wdata[1]) m_ovf[i] = 0;
            end
          endcase
        end
        m_cnt[i] = mi_nxt;
        if (mi_carry) m_ovf[i] = 1;
      end
      m_rv  = req_valid;
      m_rd  = mi_rd;
      m_irq = mi_irq;
      for (int e = 0; e < EVN; e++) m_ev[e] = int'(event_inc[e*INCW +: INCW]);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("resp_valid", 64'(resp_valid), 64'(m_rv));
      if (m_rv) chk("resp_rdata", 64'(resp_rdata), 64'(m_rd));
      chk("irq", 64'(irq), 64'(m_irq));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  task automatic set_ev(input int e, input int v);
    event_inc[e*INCW +: INCW] = INCW'(v);
  endtask

  task automatic wr(input int idx, input int fld, input logic [31:0] d);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 5'((idx << 2) | fld); req_wdata = d;
    tick();
    req_valid = 1'b0; req_we = 1'b0; req_wdata = '0;
  endtask

  task automatic rd(input int idx, input int fld, input logic [31:0] exp, input string nm);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 5'((idx << 2) | fld);
    tick();
    req_valid = 1'b0;
    chk(nm, 64'(resp_rdata), 64'(exp));
  endtask

  // Hard bound on the whole run.
  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1; event_inc = '0; freeze = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    tick(2);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_rdata", 64'(resp_rdata), 64'd0);
    chk("rst_irq", 64'(irq), 64'd0);
    rst = 1'b0;
    cmp_en = 1'b1;
    tick();
    rd(0, 1, 32'd0, "rst_cnt0");

    // Basic counting and two-cycle visibility latency.
    wr(0, 0, 32'd5);
    wr(0, 3, 32'd1);
    set_ev(5, 3);
    tick();
    rd(0, 1, 32'd0, "lat_t1");
    rd(0, 1, 32'd3, "lat_t2");
    tick(7);
    set_ev(5, 0);
    tick(2);
    rd(0, 1, 32'd30, "cnt0_30");
    chk("model_cnt0", m_cnt[0], 64'd30);

    // Overflow wrap, sticky flag, registered irq and W1C clear.
    wr(1, 2, 32'h0000_FFFF);
    wr(1, 1, 32'hFFFF_FFFE);
    wr(1, 0, 32'd0);
    wr(1, 3, 32'd5);
    set_ev(0, 3);
    tick();
    set_ev(0, 0);
    tick();
    chk("irq_not_yet", 64'(irq), 64'd0);
    tick();
    chk("irq_set", 64'(irq), 64'd1);
    rd(1, 1, 32'd1, "wrap_lo");
    rd(1, 3, 32'd7, "wrap_ctrl");
    rd(1, 2, 32'd0, "wrap_hi");
    wr(1, 3, 32'd7);
    tick();
    chk("irq_cleared", 64'(irq), 64'd0);

    // Write beats same-cycle increment.
    wr(2, 0, 32'd2);
    wr(2, 1, 32'd100);
    wr(2, 3, 32'd1);
    set_ev(2, 2);
    tick(3);
    wr(2, 1, 32'd7);
    rd(2, 1, 32'd7, "wr_wins_t1");
    rd(2, 1, 32'd9, "wr_wins_t2");
    set_ev(2, 0);
    tick(2);

    // freeze drops increments; disabled counter holds.
    wr(4, 0, 32'd7);
    wr(4, 3, 32'd1);
    set_ev(7, 1);
    tick(3);
    freeze = 1'b1;
    tick(4);
    freeze = 1'b0;
    tick(5);
    set_ev(7, 0);
    tick(2);
    rd(4, 1, 32'd8, "freeze_short4");
    wr(4, 3, 32'd0);
    set_ev(7, 1);
    tick(5);
    set_ev(7, 0);
    tick(2);
    rd(4, 1, 32'd8, "disabled_hold");

    // Hi shadow coherence and SEL write masking.
    wr(3, 2, 32'h0000_1234);
    wr(3, 1, 32'h0000_0005);
    wr(3, 0, 32'hFFFF_FFE9);
    rd(3, 0, 32'd9, "sel_mask");
    wr(3, 3, 32'd1);
    rd(3, 1, 32'h5, "shadow_lo");
    set_ev(9, 7);
    tick();
    set_ev(9, 0);
    tick(2);
    rd(3, 2, 32'h1234, "shadow_hi");
    rd(3, 1, 32'd12, "shadow_lo_after");

    // Overflow coinciding with W1C clear: set wins.
    wr(1, 2, 32'h0000_FFFF);
    wr(1, 1, 32'hFFFF_FFFF);
    set_ev(0, 1);
    tick();
    set_ev(0, 0);
    wr(1, 3, 32'd7);
    rd(1, 3, 32'd7, "set_beats_clr");
    rd(1, 1, 32'd0, "wrap_to_zero");
    chk("irq_after_set", 64'(irq), 64'd1);

    // Out-of-range counter index on the 6-counter instance.
    wr(7, 1, 32'h55);
    wr(6, 3, 32'd4);
    wr(5, 1, 32'h66);
    rd(7, 1, 32'h55, "idx7_main");
    chk("idx7_small", 64'(resp_rdata6), 64'd0);
    chk("idx7_small_valid", 64'(resp_valid6), 64'd1);
    rd(6, 3, 32'd4, "idx6_main");
    chk("idx6_small", 64'(resp_rdata6), 64'd0);
    rd(5, 1, 32'h66, "idx5_main");
    chk("idx5_small", 64'(resp_rdata6), 64'h66);

    // Mid-stream reset drops the pending response and clears everything.
    wr(0, 3, 32'd1);
    set_ev(5, 3);
    tick(3);
    rst = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 5'((0 << 2) | 1);
    tick();
    req_valid = 1'b0;
    event_inc = '0;
    chk("rst_mid_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_mid_irq", 64'(irq), 64'd0);
    chk("rst_mid_irq6", 64'(irq6), 64'd0);
    rst = 1'b0;
    rd(0, 1, 32'd0, "rst_mid_cnt0");
    rd(1, 3, 32'd0, "rst_mid_ctrl1");
    rd(1, 1, 32'd0, "rst_mid_cnt1");
    rd(0, 0, 32'd0, "rst_mid_sel0");
    rd(3, 2, 32'd0, "rst_mid_shadow");
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
